// File: rtl/l1tol2_req_arbiter_pkg.sv
// Shared types for the L1-to-L2 request arbiter: request payload layout,
// statistics counter type and the round-robin pointer advance helper.
package l1tol2_req_arbiter_pkg;

  // Width of one l1tol2_req payload.
  localparam int REQ_W = 36;

  // Request payload as issued by an L1 cache, packed MSB first.
  typedef struct packed {
    logic [4:0]  l1id;
    logic [2:0]  cmd;
    logic [12:0] pcsign;
    logic [11:0] poffset;
    logic [2:0]  ppaddr;
  } I_l1tol2_req_type;

  // Per-requester grant counter.
  typedef logic [7:0] L1ARB_stat_type;
  localparam L1ARB_stat_type STAT_MAX = 8'hFF;

  // Priority moves to the requester after the winner, wrapping to 0.
  function automatic int next_ptr(input int winner, input int nreq);
    return (winner == nreq - 1) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/l1tol2_req_arbiter_rr_pick.sv
// Combinational NREQ-way round-robin picker: returns the first valid
// requester at or after i_rr_ptr, wrapping modulo NREQ.
module l1tol2_rr_pick #(
  parameter int NREQ = 2,
  parameter int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [SRCW-1:0] i_rr_ptr,
  output logic            o_any_valid,
  output logic [SRCW-1:0] o_winner
);

  // Scan from the furthest candidate back to rr_ptr so the closest valid one wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_any_valid = |i_valid;
    o_winner    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_valid[(int'(i_rr_ptr) + k) % NREQ]) begin
        o_winner = SRCW'((int'(i_rr_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/l1tol2_req_arbiter.sv
// l1tol2_req_arbiter: merges NREQ L1 request channels onto the single
// l2cache_pipe request input. Round-robin arbitration, one registered
// output entry, valid/retry handshake on every side.
// Optional per-requester grant counters: define L1TOL2_ARB_STATS_EN.
module l1tol2_req_arbiter
  import l1tol2_req_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       in_req_valid,
  output logic [NREQ-1:0]       in_req_retry,
  input  logic [NREQ*REQ_W-1:0] in_req,
  output logic                  l1tol2_req_valid,
  input  logic                  l1tol2_req_retry,
  output logic [REQ_W-1:0]      l1tol2_req,
  output logic [SRCW-1:0]       l1tol2_req_src,
  output logic [NREQ*8-1:0]     stat_grants
);

  logic             r_valid;
  I_l1tol2_req_type r_req;
  logic [SRCW-1:0]  r_src;
  logic [SRCW-1:0]  r_rr_ptr;

  logic             w_any_valid;
  logic [SRCW-1:0]  w_winner;
  logic             w_ready;
  logic             w_grant;
  I_l1tol2_req_type w_win_req;

  l1tol2_rr_pick #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_pick (
    .i_valid     (in_req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_any_valid (w_any_valid),
    .o_winner    (w_winner)
  );

  // The entry can accept when it is empty or being drained this cycle.
  assign w_ready   = !r_valid || !l1tol2_req_retry;
  assign w_grant   = w_ready && w_any_valid;
  assign w_win_req = I_l1tol2_req_type'(in_req[w_winner*REQ_W +: REQ_W]);

  // Only the granted requester sees retry low; everyone is retried during reset.
  always_comb begin
    in_req_retry = '1;
    if (!reset && w_grant) begin
      in_req_retry[w_winner] = 1'b0;
    end
  end

  // Output entry and round-robin pointer: load on grant, empty when drained, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_req    <= '0;
      r_src    <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_valid  <= 1'b1;
      r_req    <= w_win_req;
      r_src    <= w_winner;
      r_rr_ptr <= SRCW'(next_ptr(int'(w_winner), NREQ));
    end else if (w_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign l1tol2_req_valid = r_valid;
  assign l1tol2_req       = r_req;
  assign l1tol2_req_src   = r_src;

`ifdef L1TOL2_ARB_STATS_EN
  L1ARB_stat_type r_stat [NREQ];

  // Saturating grant counter per requester, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this counter array is reset explicitly because software reads it from zero.
      for (int i = 0; i < NREQ; i++) r_stat[i] <= '0;
    end else if (w_grant && (r_stat[w_winner] != STAT_MAX)) begin
      r_stat[w_winner] <= r_stat[w_winner] + L1ARB_stat_type'(1);
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    for (int i = 0; i < NREQ; i++) stat_grants[i*8 +: 8] = r_stat[i];
  end
`else
  assign stat_grants = '0;
`endif

endmodule
